// File: rtl/c_bus_regfile.sv
// Mic-1 register file and memory port: latches the C bus into the selected registers,
// drives the B bus / H into the ALU and issues rd, wr and fetch transactions.
module c_bus_regfile #(
   parameter logic [31:0] PC_INIT  = 32'hFFFF_FFFF,
   parameter logic [31:0] SP_INIT  = 32'h0000_0000,
   parameter logic [31:0] LV_INIT  = 32'h0000_0000,
   parameter logic [31:0] CPP_INIT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] c_bus,
   input  logic [8:0]  c_sel,
   input  logic [3:0]  b_sel,
   output logic [31:0] b_bus,
   output logic [31:0] h_out,
   input  logic [2:0]  mem_op,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        dmem_rreq,
   output logic        dmem_wreq,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_rvalid,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [7:0]  imem_rdata,
   input  logic        imem_rvalid,
   output logic        busy,
   output logic        protocol_err
);

   logic [31:0] h, opc, tos, cpp, lv, sp, pc, mdr, mar;
   logic [7:0]  mbr;
   logic        rd_pend, fetch_pend;

   logic        wr_op, rd_op, fetch_op;
   logic        rd_accept, fetch_accept, rd_done, fetch_done, conflict;
   logic [31:0] mar_fwd, mdr_fwd, pc_fwd;

   // Handshake: rreq/wreq/imem_req are single-cycle pulses with no ready. A read or
   // fetch completes on the first rvalid pulse seen while it is tracked as outstanding;
   // rvalid at any other time is ignored.
   always_comb begin
      wr_op        = mem_op[2];
      rd_op        = mem_op[1];
      fetch_op     = mem_op[0];
      rd_accept    = rd_op && !wr_op && !rd_pend;
      fetch_accept = fetch_op && !fetch_pend;
      rd_done      = dmem_rvalid && rd_pend;
      fetch_done   = imem_rvalid && fetch_pend;
      conflict     = (rd_op && (wr_op || rd_pend)) || (fetch_op && fetch_pend) ||
                     (rd_done && c_sel[1]);
      mar_fwd      = c_sel[0] ? c_bus : mar;
      mdr_fwd      = c_sel[1] ? c_bus : mdr;
      pc_fwd       = c_sel[2] ? c_bus : pc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h   <= '0;
         opc <= '0;
         tos <= '0;
         cpp <= CPP_INIT;
         lv  <= LV_INIT;
         sp  <= SP_INIT;
         pc  <= PC_INIT;
         mdr <= '0;
         mar <= '0;
         mbr <= '0;
      end else begin
         if (c_sel[8]) h   <= c_bus;
         if (c_sel[7]) opc <= c_bus;
         if (c_sel[6]) tos <= c_bus;
         if (c_sel[5]) cpp <= c_bus;
         if (c_sel[4]) lv  <= c_bus;
         if (c_sel[3]) sp  <= c_bus;
         if (c_sel[2]) pc  <= c_bus;
         if (c_sel[0]) mar <= c_bus;
         // A C-bus write to MDR beats returning read data in the same cycle.
         if (c_sel[1])     mdr <= c_bus;
         else if (rd_done) mdr <= dmem_rdata;
         if (fetch_done) mbr <= imem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend      <= 1'b0;
         fetch_pend   <= 1'b0;
         protocol_err <= 1'b0;
         dmem_rreq    <= 1'b0;
         dmem_wreq    <= 1'b0;
         imem_req     <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         imem_addr    <= '0;
      end else begin
         dmem_rreq <= rd_accept;
         dmem_wreq <= wr_op;
         imem_req  <= fetch_accept;
         if (rd_accept || wr_op) dmem_addr  <= mar_fwd;
         if (wr_op)              dmem_wdata <= mdr_fwd;
         if (fetch_accept)       imem_addr  <= pc_fwd;
         if (rd_accept)    rd_pend <= 1'b1;
         else if (rd_done) rd_pend <= 1'b0;
         if (fetch_accept)    fetch_pend <= 1'b1;
         else if (fetch_done) fetch_pend <= 1'b0;
         if (conflict) protocol_err <= 1'b1;
      end
   end

   always_comb begin
      b_bus = '0;
      case (b_sel)
         4'd0:    b_bus = mdr;
         4'd1:    b_bus = pc;
         4'd2:    b_bus = {{24{mbr[7]}}, mbr};
         4'd3:    b_bus = {24'h0, mbr};
         4'd4:    b_bus = sp;
         4'd5:    b_bus = lv;
         4'd6:    b_bus = cpp;
         4'd7:    b_bus = tos;
         4'd8:    b_bus = opc;
         default: b_bus = '0;
      endcase
   end

   assign h_out = h;
   assign busy  = rd_pend || fetch_pend;

endmodule

// File: tb/tb_c_bus_regfile.sv
// Bench for c_bus_regfile: directed scenarios followed by randomized microinstruction
// streams, all compared against a register-array reference model.
module tb_c_bus_regfile;

   localparam logic [31:0] SP_I  = 32'h0000_1000;
   localparam logic [31:0] LV_I  = 32'h0000_2000;
   localparam logic [31:0] CPP_I = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] c_bus = '0;
   logic [8:0]  c_sel = '0;
   logic [3:0]  b_sel = '0;
   logic [31:0] b_bus, h_out, dmem_addr, dmem_wdata, imem_addr;
   logic [2:0]  mem_op = '0;
   logic        dmem_rreq, dmem_wreq, imem_req, busy, protocol_err;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_rvalid = 1'b0;
   logic [7:0]  imem_rdata = '0;
   logic        imem_rvalid = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   // reference model: register array indexed by c_sel bit (0 MAR .. 8 H)
   logic [31:0] m_reg [9];
   logic [7:0]  m_mbr;
   logic [31:0] m_addr, m_wdata, m_iaddr;
   logic        m_rd_pend, m_f_pend, m_err, m_rreq, m_wreq, m_ireq;

   c_bus_regfile #(
      .PC_INIT(32'hFFFF_FFFF), .SP_INIT(SP_I), .LV_INIT(LV_I), .CPP_INIT(CPP_I)
   ) dut (
      .clk(clk), .rst(rst), .c_bus(c_bus), .c_sel(c_sel), .b_sel(b_sel),
      .b_bus(b_bus), .h_out(h_out), .mem_op(mem_op), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rreq(dmem_rreq), .dmem_wreq(dmem_wreq),
      .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .imem_addr(imem_addr),
      .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
      .busy(busy), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] b_model(input logic [3:0] s);
      case (s)
         4'd0:    return m_reg[1];
         4'd1:    return m_reg[2];
         4'd2:    return 32'(signed'(m_mbr));
         4'd3:    return 32'(m_mbr);
         4'd4:    return m_reg[3];
         4'd5:    return m_reg[4];
         4'd6:    return m_reg[5];
         4'd7:    return m_reg[6];
         4'd8:    return m_reg[7];
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 9; i++) m_reg[i] = '0;
      m_reg[2] = 32'hFFFF_FFFF;
      m_reg[3] = SP_I;
      m_reg[4] = LV_I;
      m_reg[5] = CPP_I;
      m_mbr = '0; m_addr = '0; m_wdata = '0; m_iaddr = '0;
      m_rd_pend = 1'b0; m_f_pend = 1'b0; m_err = 1'b0;
      m_rreq = 1'b0; m_wreq = 1'b0; m_ireq = 1'b0;
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_step();
      logic [31:0] fwd [9];
      logic wr, rd, fe, rd_ok, fe_ok, rd_done, f_done;
      for (int i = 0; i < 9; i++) fwd[i] = c_sel[i] ? c_bus : m_reg[i];
      wr = mem_op[2]; rd = mem_op[1]; fe = mem_op[0];
      rd_ok   = rd && !wr && !m_rd_pend;
      fe_ok   = fe && !m_f_pend;
      rd_done = dmem_rvalid && m_rd_pend;
      f_done  = imem_rvalid && m_f_pend;
      if ((rd && (wr || m_rd_pend)) || (fe && m_f_pend) || (rd_done && c_sel[1])) m_err = 1'b1;
      m_rreq = rd_ok; m_wreq = wr; m_ireq = fe_ok;
      if (rd_ok || wr) m_addr = fwd[0];
      if (wr) m_wdata = fwd[1];
      if (fe_ok) m_iaddr = fwd[2];
      if (f_done) m_mbr = imem_rdata;
      m_rd_pend = rd_ok || (m_rd_pend && !rd_done);
      m_f_pend  = fe_ok || (m_f_pend && !f_done);
      for (int i = 0; i < 9; i++) m_reg[i] = fwd[i];
      if (rd_done && !c_sel[1]) m_reg[1] = dmem_rdata;
   endtask

   task automatic check_all();
      check("b_bus", b_bus, b_model(b_sel));
      check("h_out", h_out, m_reg[8]);
      check("dmem_addr", dmem_addr, m_addr);
      check("dmem_wdata", dmem_wdata, m_wdata);
      check("imem_addr", imem_addr, m_iaddr);
      check_bit("dmem_rreq", dmem_rreq, m_rreq);
      check_bit("dmem_wreq", dmem_wreq, m_wreq);
      check_bit("imem_req", imem_req, m_ireq);
      check_bit("busy", busy, m_rd_pend || m_f_pend);
      check_bit("protocol_err", protocol_err, m_err);
   endtask

   // Drive one microinstruction cycle; afterwards inputs return to idle just past the edge.
   task automatic step(input logic [31:0] cb, input logic [8:0] cs, input logic [3:0] bs,
                       input logic [2:0] op, input logic rv, input logic [31:0] rdat,
                       input logic irv, input logic [7:0] irdat);
      @(negedge clk);
      c_bus = cb; c_sel = cs; b_sel = bs; mem_op = op;
      dmem_rvalid = rv; dmem_rdata = rdat; imem_rvalid = irv; imem_rdata = irdat;
      #1;
      check_all();
      model_step();
      @(posedge clk);
      #1;
      c_sel = '0; mem_op = '0; dmem_rvalid = 1'b0; imem_rvalid = 1'b0;
   endtask

   task automatic probe_b(input string tag, input logic [3:0] bs, input logic [31:0] exp);
      b_sel = bs;
      #1;
      check(tag, b_bus, exp);
   endtask

   // Reset asserted between clock edges; outputs must clear without waiting for an edge.
   task automatic do_reset();
      @(negedge clk);
      c_sel = '0; mem_op = '0; dmem_rvalid = 1'b0; imem_rvalid = 1'b0;
      #1 rst = 1'b1;
      #1;
      model_reset();
      check_bit("rst_rreq", dmem_rreq, 1'b0);
      check_bit("rst_wreq", dmem_wreq, 1'b0);
      check_bit("rst_ireq", imem_req, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_err", protocol_err, 1'b0);
      check("rst_h", h_out, 32'h0);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [31:0] cb, rdat;
      logic [8:0]  cs;
      logic [2:0]  op;
      logic        rv, irv;

      // reset values
      do_reset();
      probe_b("rst_pc", 4'd1, 32'hFFFF_FFFF);
      probe_b("rst_sp", 4'd4, SP_I);
      probe_b("rst_lv", 4'd5, LV_I);
      probe_b("rst_cpp", 4'd6, CPP_I);
      probe_b("rst_mdr", 4'd0, 32'h0);
      probe_b("rst_tos", 4'd7, 32'h0);
      probe_b("rst_opc", 4'd8, 32'h0);
      probe_b("rst_mbr", 4'd3, 32'h0);
      probe_b("bsel_9", 4'd9, 32'h0);
      probe_b("bsel_15", 4'd15, 32'h0);

      // fetch from reset: PC = PC+1 forwarded to the fetch address
      step(32'hFFFF_FFFF + 32'd1, 9'h004, 4'd1, 3'b001, 1'b0, '0, 1'b0, '0);
      check_bit("fetch_req", imem_req, 1'b1);
      check("fetch_addr", imem_addr, 32'h0);
      check_bit("fetch_busy", busy, 1'b1);
      step('0, 9'h000, 4'd0, 3'b000, 1'b0, '0, 1'b1, 8'hF0);
      probe_b("mbr_sext", 4'd2, 32'hFFFF_FFF0);
      probe_b("mbr_zext", 4'd3, 32'h0000_00F0);
      check_bit("fetch_done_busy", busy, 1'b0);

      // C bus fan-out to H, OPC, TOS
      step(32'h0000_1234, 9'h1C0, 4'd0, 3'b000, 1'b0, '0, 1'b0, '0);
      check("fan_h", h_out, 32'h0000_1234);
      probe_b("fan_tos", 4'd7, 32'h0000_1234);
      probe_b("fan_opc", 4'd8, 32'h0000_1234);

      // read with MAR forwarded from the C bus
      step(32'h10, 9'h001, 4'd0, 3'b010, 1'b0, '0, 1'b0, '0);
      check_bit("rd_rreq", dmem_rreq, 1'b1);
      check("rd_addr", dmem_addr, 32'h10);
      check_bit("rd_busy", busy, 1'b1);
      step('0, 9'h000, 4'd0, 3'b000, 1'b1, 32'hCAFE_0001, 1'b0, '0);
      probe_b("rd_mdr", 4'd0, 32'hCAFE_0001);
      check_bit("rd_done_busy", busy, 1'b0);
      check_bit("rd_err", protocol_err, 1'b0);

      // second rd while outstanding, then rvalid colliding with a C-bus MDR write
      step('0, 9'h000, 4'd0, 3'b010, 1'b0, '0, 1'b0, '0);
      step('0, 9'h000, 4'd0, 3'b010, 1'b0, '0, 1'b0, '0);
      check_bit("dup_rreq", dmem_rreq, 1'b0);
      check_bit("dup_err", protocol_err, 1'b1);
      step(32'h5, 9'h002, 4'd0, 3'b000, 1'b1, 32'hDEAD_BEEF, 1'b0, '0);
      probe_b("coll_mdr", 4'd0, 32'h5);
      check_bit("coll_busy", busy, 1'b0);

      // write with MDR forwarded from the C bus
      step(32'h77, 9'h002, 4'd0, 3'b100, 1'b0, '0, 1'b0, '0);
      check("wr_data", dmem_wdata, 32'h77);
      check_bit("wr_wreq", dmem_wreq, 1'b1);
      check_bit("wr_busy", busy, 1'b0);
      step('0, 9'h000, 4'd0, 3'b000, 1'b0, '0, 1'b0, '0);
      check_bit("wr_wreq_drop", dmem_wreq, 1'b0);

      // randomized streams, with a mid-run reset followed by a stray rvalid
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         step('0, 9'h000, 4'd0, 3'b000, 1'b1, 32'h1111_2222, 1'b1, 8'h33);
         for (int i = 0; i < 300; i++) begin
            cb   = $urandom;
            rdat = $urandom;
            cs   = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 511)) : 9'h000;
            op   = {$urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 30};
            rv   = m_rd_pend ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            irv  = m_f_pend ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            step(cb, cs, 4'($urandom_range(0, 15)), op, rv, rdat, irv, 8'($urandom_range(0, 255)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
